uart_tx_frame_ctrl: RTL

Control stage directly upstream of the transmit PISO in the UART transmitter. It accepts bytes over a valid/ready interface and buffers them in a small FIFO. For each byte it builds the 11-bit frame (start, 8 data, parity, stop), drives `data_frame` and `piso_start` into the PISO, and sequences frames back-to-back using the PISO's `done_flag`. Everything runs in the baud clock domain.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_frame_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame layout, FSM state encodings and frame builder.
package uart_pkg;

  localparam int unsigned FRAME_W   = 11;
  localparam int unsigned START_BIT = 0;
  localparam int unsigned DATA_LSB  = 1;
  localparam int unsigned PAR_BIT   = 9;
  localparam int unsigned STOP_BIT  = 10;

  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // With parity disabled bit 9 keeps its all-ones default and acts as a second stop bit.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data,
                                                     input logic       par_en,
                                                     input logic       par_odd);
    logic [FRAME_W-1:0] f;
    f                = '1;
    f[START_BIT]     = 1'b0;
    f[DATA_LSB +: 8] = data;
    if (par_en) f[PAR_BIT] = (^data) ^ par_odd;
    f[STOP_BIT]      = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty decoded from the pointer pair.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_INC;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// Byte FIFO plus frame sequencer feeding the transmit PISO in the baud clock domain.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic               baud_clk,
  input  logic               rst,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] data_frame,
  output logic               piso_start,
  input  logic               active_flag,
  input  logic               done_flag,
  output logic               busy
);

  state_t             state_q, state_d;
  logic               seen_act_q, seen_act_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (baud_clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // done_flag only counts once active_flag was sampled high at an earlier edge of
  // this SEND, which rejects a done left over from the previous frame.
  always_comb begin
    state_d    = state_q;
    seen_act_d = seen_act_q;
    frame_d    = frame_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        pop        = 1'b1;
        frame_d    = build_frame(head, PARITY_EN, PARITY_ODD);
        seen_act_d = 1'b0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        seen_act_d = seen_act_q | active_flag;
        if (done_flag && seen_act_q) state_d = ST_GAP;
      end
      ST_GAP:  state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seen_act_q <= 1'b0;
      frame_q    <= IDLE_FRAME;
    end else begin
      state_q    <= state_d;
      seen_act_q <= seen_act_d;
      frame_q    <= frame_d;
    end
  end

  assign data_frame = frame_q;
  assign piso_start = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
